fetch_unit: RTL and testbench

Instruction fetch stage for the single-issue RV32I core. Holds the program counter and issues one-at-a-time requests to instruction memory over a ready/valid handshake. Buffers the returned word and presents `instr`/`instr_valid` to the decode/control stage, which consumes it combinationally. Accepts a one-cycle redirect (taken branch or jump, generated from PCSel and the ALU target) that flushes everything in flight.

---
 rtl/fetch_unit_if.sv | 12 +
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory request/response channel between the fetch stage and imem
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            req;
    logic [XLEN-1:0] addr;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: RV32I fetch stage with one outstanding imem request, an output register and a one-entry skid buffer
module fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_unit_if.master    imem,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            stall,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;
    state_t          state, state_n;
    logic [XLEN-1:0] pc, pc_n, out_q, out_n, out_pc_n;
    logic [XLEN-1:0] pend_instr, pend_instr_n, pend_pc, pend_pc_n;
    logic            drop, drop_n, valid_n, consume, load;
    assign consume   = instr_valid & ~stall;
    assign load      = ~drop & (~instr_valid | consume);
    assign imem.req  = state == REQ;
    assign imem.addr = pc;
    assign instr     = instr_valid ? out_q : NOP;
    always_comb begin
        state_n      = state;
        pc_n         = pc;
        drop_n       = drop;
        out_n        = out_q;
        out_pc_n     = instr_pc;
        valid_n      = instr_valid & ~consume;
        pend_instr_n = pend_instr;
        pend_pc_n    = pend_pc;
        case (state)
            IDLE: state_n = REQ;
            REQ:  state_n = imem.ready ? WAIT : REQ;
            WAIT: if (imem.rvalid) begin
                drop_n       = 1'b0;
                state_n      = (drop || load) ? REQ : HOLD;
                pc_n         = drop ? pc : pc + XLEN'(4);
                out_n        = load ? imem.rdata : out_q;
                out_pc_n     = load ? pc : instr_pc;
                valid_n      = load | valid_n;
                pend_instr_n = (!drop && !load) ? imem.rdata : pend_instr;
                pend_pc_n    = (!drop && !load) ? pc : pend_pc;
            end
            HOLD: if (consume) begin
                out_n    = pend_instr;
                out_pc_n = pend_pc;
                valid_n  = 1'b1;
                state_n  = REQ;
            end
        endcase
        // A redirect wins over everything; a request already accepted must have its reply discarded
        if (redirect) begin
            pc_n         = redirect_pc & ~XLEN'(3);
            valid_n      = 1'b0;
            pend_instr_n = '0;
            pend_pc_n    = '0;
            drop_n       = (state == REQ && imem.ready) || (state == WAIT && !imem.rvalid);
            state_n      = drop_n ? WAIT : REQ;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            drop        <= 1'b0;
            out_q       <= NOP;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            pend_instr  <= '0;
            pend_pc     <= '0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            drop        <= drop_n;
            out_q       <= out_n;
            instr_pc    <= out_pc_n;
            instr_valid <= valid_n;
            pend_instr  <= pend_instr_n;
            pend_pc     <= pend_pc_n;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven cycle vectors plus a scoreboarded random-latency stream for fetch_unit
module tb_fetch_unit;
    localparam logic [31:0] NOP = 32'h0000_0013;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n;
    logic        redirect, stall, w_redirect, w_stall;
    logic [31:0] redirect_pc, w_redirect_pc;
    logic [31:0] instr, instr_pc, w_instr, w_instr_pc;
    logic        instr_valid, w_instr_valid;
    fetch_unit_if #(.XLEN(32)) mif ();
    fetch_unit_if #(.XLEN(32)) wif ();
    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem(mif), .redirect(redirect), .redirect_pc(redirect_pc),
        .stall(stall), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );
    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk(clk), .rst_n(rst_n), .imem(wif), .redirect(w_redirect), .redirect_pc(w_redirect_pc),
        .stall(w_stall), .instr(w_instr), .instr_pc(w_instr_pc), .instr_valid(w_instr_valid)
    );
    typedef struct {
        logic        ready, rvalid;
        logic [31:0] raddr;
        logic        redir;
        logic [31:0] rpc;
        logic        stl;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;
    vec_t vecs[$];
    vec_t wvecs[$];
    int n_cmp = 0;
    int n_bad = 0;
    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction
    function automatic vec_t mk(input logic ready, rvalid, input logic [31:0] raddr, input logic redir,
                                input logic [31:0] rpc, input logic stl, input logic ereq,
                                input logic [31:0] eaddr, input logic evalid, input logic [31:0] epc);
        vec_t v;
        v.ready = ready; v.rvalid = rvalid; v.raddr = raddr; v.redir = redir; v.rpc = rpc;
        v.stl = stl; v.ereq = ereq; v.eaddr = eaddr; v.evalid = evalid; v.epc = epc;
        return v;
    endfunction
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask
    task automatic apply(input vec_t v, input bit wrap, input string tag);
        if (wrap) begin
            wif.ready = v.ready; wif.rvalid = v.rvalid; wif.rdata = w(v.raddr);
            w_redirect = v.redir; w_redirect_pc = v.rpc; w_stall = v.stl;
        end else begin
            mif.ready = v.ready; mif.rvalid = v.rvalid; mif.rdata = w(v.raddr);
            redirect = v.redir; redirect_pc = v.rpc; stall = v.stl;
        end
        #1;
        chk({tag, " req"},   32'(wrap ? wif.req : mif.req), 32'(v.ereq));
        chk({tag, " addr"},  wrap ? wif.addr : mif.addr, v.eaddr);
        chk({tag, " valid"}, 32'(wrap ? w_instr_valid : instr_valid), 32'(v.evalid));
        chk({tag, " instr"}, wrap ? w_instr : instr, v.evalid ? w(v.epc) : NOP);
        if (v.evalid) chk({tag, " pc"}, wrap ? w_instr_pc : instr_pc, v.epc);
    endtask
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc, maddr, e;
    logic        busy, acc, took, rv;
    int          cnt, pops;
    initial begin
        rst_n = 1'b0;
        mif.ready = 0; mif.rvalid = 0; mif.rdata = 0;
        wif.ready = 0; wif.rvalid = 0; wif.rdata = 0;
        redirect = 0; redirect_pc = 0; stall = 0;
        w_redirect = 0; w_redirect_pc = 0; w_stall = 0;
        vecs.push_back(mk(1,0,0,      0,0,0,    0,0,0,0));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,0,0,0));
        vecs.push_back(mk(0,1,0,      0,0,0,    0,0,0,0));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,4,1,0));
        vecs.push_back(mk(0,1,4,      0,0,0,    0,4,0,0));
        vecs.push_back(mk(1,0,0,      0,0,1,    1,8,1,4));
        vecs.push_back(mk(0,1,8,      0,0,1,    0,8,1,4));
        for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0, 0,0,1, 0,12,1,4));
        vecs.push_back(mk(1,0,0,      0,0,0,    0,12,1,4));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,12,1,8));
        vecs.push_back(mk(0,0,0,      1,'h100,0, 0,12,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,    0,'h100,0,0));
        vecs.push_back(mk(0,1,12,     0,0,0,    0,'h100,0,0));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,'h100,0,0));
        vecs.push_back(mk(0,1,'h100,  0,0,0,    0,'h100,0,0));
        vecs.push_back(mk(1,0,0,      1,'h203,0, 1,'h104,1,'h100));
        vecs.push_back(mk(0,1,'h104,  0,0,0,    0,'h200,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,    1,'h200,0,0));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,'h200,0,0));
        vecs.push_back(mk(0,1,'h200,  0,0,0,    0,'h200,0,0));
        vecs.push_back(mk(1,0,0,      0,0,1,    1,'h204,1,'h200));
        vecs.push_back(mk(0,1,'h204,  0,0,1,    0,'h204,1,'h200));
        vecs.push_back(mk(0,0,0,      1,'h40,1, 0,'h208,1,'h200));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,'h40,0,0));
        vecs.push_back(mk(0,1,'h40,   0,0,0,    0,'h40,0,0));
        vecs.push_back(mk(0,0,0,      0,0,0,    1,'h44,1,'h40));
        vecs.push_back(mk(0,0,0,      1,'h80,0, 1,'h44,0,0));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,'h80,0,0));
        vecs.push_back(mk(0,1,'h80,   1,'hC0,0, 0,'h80,0,0));
        vecs.push_back(mk(1,0,0,      0,0,0,    1,'hC0,0,0));
        vecs.push_back(mk(0,1,'hC0,   0,0,0,    0,'hC0,0,0));
        vecs.push_back(mk(0,0,0,      0,0,1,    1,'hC4,1,'hC0));
        wvecs.push_back(mk(1,0,0,     0,0,0,    0,'hFFFF_FFFC,0,0));
        wvecs.push_back(mk(1,0,0,     0,0,0,    1,'hFFFF_FFFC,0,0));
        wvecs.push_back(mk(0,1,'hFFFF_FFFC, 0,0,0, 0,'hFFFF_FFFC,0,0));
        wvecs.push_back(mk(1,0,0,     0,0,0,    1,0,1,'hFFFF_FFFC));
        wvecs.push_back(mk(0,1,0,     0,0,0,    0,0,0,0));
        wvecs.push_back(mk(0,0,0,     0,0,0,    1,4,1,0));
        repeat (2) @(negedge clk);
        #1;
        chk("reset req", 32'(mif.req), 0);
        chk("reset addr", mif.addr, 0);
        chk("reset valid", 32'(instr_valid), 0);
        chk("reset instr", instr, NOP);
        chk("reset pc", instr_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (vecs[i]) begin
            apply(vecs[i], 1'b0, $sformatf("row%0d", i));
            @(negedge clk);
        end
        mif.ready = 0; mif.rvalid = 0; stall = 1;
        #2 rst_n = 1'b0;
        #1;
        chk("async reset req", 32'(mif.req), 0);
        chk("async reset addr", mif.addr, 0);
        chk("async reset valid", 32'(instr_valid), 0);
        chk("async reset instr", instr, NOP);
        chk("async reset pc", instr_pc, 0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_pc = 0; busy = 0; cnt = 0; maddr = 0; pops = 0;
        for (int c = 0; c < 400; c++) begin
            rv = busy && cnt == 0;
            mif.rvalid = rv; mif.rdata = w(maddr);
            mif.ready = $urandom_range(0, 3) != 0;
            stall = $urandom_range(0, 2) == 0;
            redirect = 0;
            #1;
            acc = mif.req && mif.ready;
            took = instr_valid && !stall;
            if (acc) begin
                chk("stream addr", mif.addr, exp_pc);
                exp_q.push_back(exp_pc);
                exp_pc += 4;
            end
            if (took) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL stream underflow: got instr %08h expected none pending", instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("stream instr", instr, w(e));
                    chk("stream pc", instr_pc, e);
                    pops++;
                end
            end
            if (rv) busy = 0;
            if (acc) begin
                busy = 1; maddr = mif.addr; cnt = $urandom_range(0, 2);
            end else if (busy && cnt > 0) cnt--;
            @(negedge clk);
        end
        chk("stream throughput", 32'(pops >= 20), 1);
        mif.ready = 0; mif.rvalid = 0; stall = 0;
        rst_n = 1'b0;
        #1;
        chk("wrap reset addr", wif.addr, 32'hFFFF_FFFC);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (wvecs[i]) begin
            apply(wvecs[i], 1'b1, $sformatf("wrap%0d", i));
            @(negedge clk);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
